// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, opcode field constants and fetch state encoding
package mips_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 10;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam logic [5:0] OP_HALT = 6'b111111;
  typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_counter.sv
// fetch_counter: 16-bit saturating count of accepted instructions
module fetch_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);
  // count accepts, sticking at all-ones
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (inc && count != 16'hFFFF) count <= count + 16'd1;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC sequencer for an enable-less registered instruction memory; INSTR_FETCH_HALT_EN enables the halt opcode
module instruction_fetch #(
  parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = mips_pkg::ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic [ADDR_WIDTH-1:0] imem_address,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  output logic [15:0]           fetch_count,
  output logic                  halted
);
  import mips_pkg::*;
  fetch_state_t state, state_n;
  logic [ADDR_WIDTH-1:0] pc, pc_n, pc_q, pc_q_n;
  logic valid_q, valid_n;
  assign imem_address = redirect ? redirect_addr : (stall || state == HALTED) ? pc_q : pc;
  assign instr = valid_q ? imem_data : '0;
  assign instr_pc = pc_q;
  assign instr_valid = valid_q;
`ifdef INSTR_FETCH_HALT_EN
  assign halted = state == HALTED;
`else
  assign halted = 1'b0;
`endif
  // redirect beats everything; IDLE always advances, RUN advances unless stalled
  always_comb begin
    pc_n = pc;
    pc_q_n = pc_q;
    valid_n = valid_q;
    state_n = state;
    if (redirect) begin
      pc_q_n = redirect_addr;
      pc_n = redirect_addr + 1'b1;
      valid_n = 1'b1;
      state_n = RUN;
    end else if (state == IDLE || (state == RUN && !stall)) begin
      pc_q_n = pc;
      pc_n = pc + 1'b1;
      valid_n = 1'b1;
      state_n = RUN;
`ifdef INSTR_FETCH_HALT_EN
      if (state == RUN && valid_q && imem_data[OP_MSB:OP_LSB] == OP_HALT) begin
        pc_q_n = pc_q;
        pc_n = pc;
        valid_n = 1'b0;
        state_n = HALTED;
      end
`endif
    end
  end
  // fetch state and PC registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      pc_q <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      pc_q <= pc_q_n;
      valid_q <= valid_n;
    end
  fetch_counter u_fetch_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (valid_q && !stall),
    .count (fetch_count)
  );
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch-stage sequencer: owns the program counter, drives the address port of `instructionmemory`, and pairs each registered instruction word it returns with its PC and a valid flag for the decode stage. Compensates for the memory's one-cycle registered read and its lack of a read enable, so stalls and branch redirects cost no bubbles. Sits between `instructionmemory` and the IF/ID pipeline register.

## Interface
- `DATA_WIDTH`, 32, instruction word width
- `ADDR_WIDTH`, 10, word-address width (matches `instructionmemory`)
- `RESET_PC`, 0, first fetched word address
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `stall` in 1: hold current instruction (hazard unit)
- `redirect` in 1: branch/jump taken this cycle
- `redirect_addr` in ADDR_WIDTH: target word address
- `imem_address` out ADDR_WIDTH: to `instructionmemory.address`
- `imem_data` in DATA_WIDTH: from `instructionmemory.data_out`
- `instr` out DATA_WIDTH: instruction to decode; 0 when not valid
- `instr_pc` out ADDR_WIDTH: word address of `instr`
- `instr_valid` out 1: `instr` is real
- `fetch_count` out 16: accepted instructions, saturating
- `halted` out 1: fetch stopped (see Configuration)

## Operation
- Registers: `pc` (next address), `pc_q` (address of word in `imem_data`), `valid_q`, `state`, `fetch_count`.
- States: IDLE (after reset, no data yet), RUN, HALTED.
- `imem_address` (combinational), priority order: `redirect` -> `redirect_addr`; else `stall` or state HALTED -> `pc_q`; else `pc`. Re-presenting `pc_q` makes the enable-less memory re-read the same word.
- On edge with `redirect`: `pc_q <= redirect_addr`, `pc <= redirect_addr + 1`, `valid_q <= 1`, state -> RUN (from any state).
- Else in IDLE: `pc_q <= pc`, `pc <= pc + 1`, `valid_q <= 1`, -> RUN; `stall` ignored.
- Else in RUN with `stall`: all registers hold.
- Else in RUN: `pc_q <= pc`, `pc <= pc + 1`, `valid_q <= 1`.
- `pc + 1` wraps modulo 2^ADDR_WIDTH (max -> 0); no flag.
- `instr = valid_q ? imem_data : 0`; `instr_pc = pc_q`; `instr_valid = valid_q`.
- Accept = `instr_valid && !stall`; increments `fetch_count`, saturating at 16'hFFFF.
- Redirect and stall in same cycle: redirect wins; current `instr` still counts as accepted only if `!stall`.

## Timing
- Reset values: `pc = RESET_PC`, `pc_q = RESET_PC`, `valid_q = 0`, state IDLE, `fetch_count = 0`, `halted = 0`; so `instr = 0`, `instr_valid = 0`, `imem_address = RESET_PC`.
- First valid instruction (word RESET_PC) one cycle after first edge following `rst` deassertion.
- Sequential throughput: one word per cycle.
- Stall: zero-cycle resume penalty; `instr`/`instr_pc` stable while `stall` high.
- Redirect: target instruction valid on the cycle after the redirect edge; zero bubbles.
- `rst` mid-operation: all registers take reset values immediately, irrespective of `clk`.

## Configuration
- `INSTR_FETCH_HALT_EN` defined: in RUN, accepted instruction with opcode bits [31:26] = 6'b111111 and no `redirect` -> next edge state HALTED, `valid_q <= 0`, `pc`/`pc_q` frozen, `halted = 1`. HALTED exits only via `redirect` or `rst`.
- Undefined: HALTED unreachable, `halted` tied 0, opcode 6'b111111 treated as an ordinary word.

## Structure
- Shared package `mips_pkg`: `DATA_WIDTH`, `ADDR_WIDTH`, opcode field position constants, `OP_HALT = 6'b111111`, fetch state enum (IDLE, RUN, HALTED).
- One natural sub-module: `fetch_counter` (16-bit saturating accept counter with async reset). Everything else in `instruction_fetch`.

## Test plan
- Reset release with memory words 0..3 = 32'h0C0F0A00.. -> `instr_valid` 0 for one cycle, then `instr_pc` 0,1,2,3 on consecutive cycles with matching `instr`, `fetch_count` = 4.
- `stall` high 3 cycles while `instr_pc` = 2 -> `instr_pc` stays 2, `imem_address` = 2, `fetch_count` unchanged; after release `instr_pc` = 3 next cycle.
- `redirect` with `redirect_addr` = 7 while `instr_pc` = 3 -> next cycle `instr_pc` = 7, `instr` = word 7, then 8, 9.
- `pc` at 1023 -> `instr_pc` 1023 followed by 0.
- `rst` pulse mid-run (between edges) -> outputs immediately `instr` = 0, `instr_valid` = 0, `fetch_count` = 0, `imem_address` = RESET_PC.
- With `INSTR_FETCH_HALT_EN`, word 5 = 32'hFC000000 -> after accept `halted` = 1, `instr_valid` = 0, `imem_address` held; `redirect_addr` = 0 resumes at 0, `halted` = 0. Without macro, word 5 passes and 6 follows.
